// File: rtl/parking_pkg.sv
// Shared helpers for the parking zone manager: width calculators and the
// 7-segment encoder used by the display scan.
package parking_pkg;

    // Glyph for values that are not a decimal digit (a lone middle bar).
    localparam logic [6:0] SSD_BLANK = 7'b0000001;

    function automatic int calc_cw(input int max_slots);
        return $clog2(max_slots + 1);
    endfunction

    function automatic int calc_tw(input int n_zones, input int max_slots);
        return $clog2(n_zones * max_slots + 1);
    endfunction

    // Segment order is {a,b,c,d,e,f,g}, active high.
    function automatic logic [6:0] ssd_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return SSD_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/parking_zone_counter.sv
// One parking zone: capacity and occupancy registers, entry/exit arbitration
// and capacity clamp. Reject/underflow are single-cycle pulses to the top.
module parking_zone_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_we_i,
    input  logic [CW-1:0] cfg_cap_i,
    input  logic          ev_in_i,
    input  logic          ev_out_i,
    output logic [CW-1:0] cap_o,
    output logic [CW-1:0] occ_o,
    output logic          reject_o,
    output logic          underflow_o
);

    logic [CW-1:0] cap_q, cap_d;
    logic [CW-1:0] occ_q, occ_d;

    // A capacity write wins over any sensor event in the same cycle; a
    // simultaneous entry and exit is a swap and leaves occupancy untouched.
    always_comb begin
        cap_d       = cap_q;
        occ_d       = occ_q;
        reject_o    = 1'b0;
        underflow_o = 1'b0;
        if (cfg_we_i) begin
            cap_d = cfg_cap_i;
            if (occ_q > cfg_cap_i) begin
                occ_d = cfg_cap_i;
            end
        end else if (ev_in_i && !ev_out_i) begin
            if (occ_q < cap_q) begin
                occ_d = occ_q + CW'(1);
            end else begin
                reject_o = 1'b1;
            end
        end else if (ev_out_i && !ev_in_i) begin
            if (occ_q != '0) begin
                occ_d = occ_q - CW'(1);
            end else begin
                underflow_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
            occ_q <= '0;
        end else begin
            cap_q <= cap_d;
            occ_q <= occ_d;
        end
    end

    assign cap_o = cap_q;
    assign occ_o = occ_q;

endmodule

// File: rtl/parking_zone_manager.sv
// Multi-zone parking manager: sensor edge detect, per-zone counters, free
// total, reject/underflow status and a 2-digit multiplexed display.
// Optional peak-occupancy register is built when PEAK_HOLD_EN is defined.
module parking_zone_manager
    import parking_pkg::*;
#(
    parameter  int N_ZONES   = 4,
    parameter  int MAX_SLOTS = 15,
    parameter  int SCAN_DIV  = 50000,
    localparam int CW        = calc_cw(MAX_SLOTS),
    localparam int TW        = calc_tw(N_ZONES, MAX_SLOTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_zone,
    input  logic [CW-1:0]         cfg_cap,
    input  logic                  enable,
    input  logic [N_ZONES-1:0]    car_in,
    input  logic [N_ZONES-1:0]    car_out,
    output logic [N_ZONES*CW-1:0] zone_free,
    output logic [N_ZONES-1:0]    zone_full,
    output logic [TW-1:0]         total_free,
    output logic [15:0]           reject_cnt,
    output logic                  underflow_err,
    output logic [TW-1:0]         peak_occ,
    output logic [6:0]            seg,
    output logic                  digit_sel
);

    localparam int            SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [N_ZONES-1:0] in_q, in_qq, out_q, out_qq;
    logic [N_ZONES-1:0] evIn, evOut;
    logic [N_ZONES-1:0] rejPulse, ufPulse;
    logic [CW-1:0]      capArr  [N_ZONES];
    logic [CW-1:0]      occArr  [N_ZONES];
    logic [CW-1:0]      freeArr [N_ZONES];
    logic [CW-1:0]      capSat;
    logic [TW-1:0]      freeSum, total_free_q;
    logic [16:0]        rejSum;
    logic [15:0]        reject_cnt_q, reject_cnt_d;
    logic               underflow_q;
    logic [SW-1:0]      scan_q;
    logic               digit_sel_q;
    logic [6:0]         seg_q, seg_d;
    logic [6:0]         dispVal;
    logic [3:0]         tens, ones;

    // Second stage keeps tracking while disabled, so a sensor held high
    // across an enable rise never produces a late event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= '0;
            in_qq  <= '0;
            out_q  <= '0;
            out_qq <= '0;
        end else begin
            in_q   <= car_in;
            in_qq  <= in_q;
            out_q  <= car_out;
            out_qq <= out_q;
        end
    end

    assign evIn   = in_q  & ~in_qq  & {N_ZONES{enable}};
    assign evOut  = out_q & ~out_qq & {N_ZONES{enable}};
    assign capSat = (cfg_cap > CW'(MAX_SLOTS)) ? CW'(MAX_SLOTS) : cfg_cap;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        parking_zone_counter #(.CW(CW)) u_cnt (
            .clk         (clk),
            .reset_n     (reset_n),
            .cfg_we_i    (cfg_we && (cfg_zone == 3'(z))),
            .cfg_cap_i   (capSat),
            .ev_in_i     (evIn[z]),
            .ev_out_i    (evOut[z]),
            .cap_o       (capArr[z]),
            .occ_o       (occArr[z]),
            .reject_o    (rejPulse[z]),
            .underflow_o (ufPulse[z])
        );
        assign freeArr[z]             = capArr[z] - occArr[z];
        assign zone_free[z*CW +: CW]  = freeArr[z];
        assign zone_full[z]           = (occArr[z] >= capArr[z]);
    end

    // Several zones may refuse a car in the same cycle; each one counts.
    always_comb begin
        freeSum = '0;
        rejSum  = {1'b0, reject_cnt_q};
        for (int z = 0; z < N_ZONES; z++) begin
            freeSum = freeSum + TW'(freeArr[z]);
            rejSum  = rejSum + 17'(rejPulse[z]);
        end
        reject_cnt_d = (rejSum > 17'h0FFFF) ? 16'hFFFF : rejSum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_free_q <= '0;
            reject_cnt_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            total_free_q <= freeSum;
            reject_cnt_q <= reject_cnt_d;
            underflow_q  <= underflow_q | (|ufPulse);
        end
    end

`ifdef PEAK_HOLD_EN
    logic [TW-1:0] occSum, peak_q;

    always_comb begin
        occSum = '0;
        for (int z = 0; z < N_ZONES; z++) begin
            occSum = occSum + TW'(occArr[z]);
        end
    end

    // Any capacity write restarts peak tracking from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else if (cfg_we) begin
            peak_q <= '0;
        end else if (occSum > peak_q) begin
            peak_q <= occSum;
        end
    end

    assign peak_occ = peak_q;
`else
    assign peak_occ = '0;
`endif

    // Two digits can show at most 99 free slots.
    assign dispVal = (int'(total_free_q) > 99) ? 7'd99 : 7'(total_free_q);
    assign tens    = 4'(dispVal / 7'd10);
    assign ones    = 4'(dispVal % 7'd10);
    assign seg_d   = ssd_encode(digit_sel_q ? ones : tens);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q      <= '0;
            digit_sel_q <= 1'b0;
            seg_q       <= 7'b1111110;
        end else begin
            seg_q <= seg_d;
            if (scan_q == SCAN_LAST) begin
                scan_q      <= '0;
                digit_sel_q <= ~digit_sel_q;
            end else begin
                scan_q <= scan_q + SW'(1);
            end
        end
    end

    assign total_free    = total_free_q;
    assign reject_cnt    = reject_cnt_q;
    assign underflow_err = underflow_q;
    assign seg           = seg_q;
    assign digit_sel     = digit_sel_q;

endmodule

// File: tb/tb_parking_zone_manager.sv
// Scoreboard bench for parking_zone_manager: stimulus pushes expected values,
// a negedge monitor pops and compares them when a sample is requested.
module tb_parking_zone_manager;

    localparam int N_ZONES   = 4;
    localparam int MAX_SLOTS = 15;
    localparam int SCAN_DIV  = 4;
    localparam int CW        = 4;
    localparam int TW        = 6;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  cfg_we = 1'b0;
    logic [2:0]            cfg_zone = '0;
    logic [CW-1:0]         cfg_cap = '0;
    logic                  enable = 1'b0;
    logic [N_ZONES-1:0]    car_in = '0;
    logic [N_ZONES-1:0]    car_out = '0;
    logic [N_ZONES*CW-1:0] zone_free;
    logic [N_ZONES-1:0]    zone_full;
    logic [TW-1:0]         total_free;
    logic [15:0]           reject_cnt;
    logic                  underflow_err;
    logic [TW-1:0]         peak_occ;
    logic [6:0]            seg;
    logic                  digit_sel;

    // Second instance with a smaller zone limit to exercise capacity saturation.
    logic [0:0] car2 = 1'b0;
    logic [3:0] zone_free2;
    logic [0:0] zone_full2;
    logic [3:0] total_free2;
    logic [15:0] reject_cnt2;
    logic       underflow_err2;
    logic [3:0] peak_occ2;
    logic [6:0] seg2;
    logic       digit_sel2;

    always #5 clk = ~clk;

    parking_zone_manager #(.N_ZONES(N_ZONES), .MAX_SLOTS(MAX_SLOTS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_cap(cfg_cap),
        .enable(enable), .car_in(car_in), .car_out(car_out), .zone_free(zone_free),
        .zone_full(zone_full), .total_free(total_free), .reject_cnt(reject_cnt),
        .underflow_err(underflow_err), .peak_occ(peak_occ), .seg(seg), .digit_sel(digit_sel)
    );

    parking_zone_manager #(.N_ZONES(1), .MAX_SLOTS(10), .SCAN_DIV(SCAN_DIV)) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_cap(cfg_cap),
        .enable(enable), .car_in(car2), .car_out(car2), .zone_free(zone_free2),
        .zone_full(zone_full2), .total_free(total_free2), .reject_cnt(reject_cnt2),
        .underflow_err(underflow_err2), .peak_occ(peak_occ2), .seg(seg2), .digit_sel(digit_sel2)
    );

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } expT;

    expT  sbq[$];
    int   testCount = 0;
    int   failCount = 0;
    logic sampleReq = 1'b0;

    function automatic logic [31:0] getActual(input expT e);
        case (e.sel)
            0:       return 32'(zone_free[e.idx*CW +: CW]);
            1:       return 32'(zone_full[e.idx]);
            2:       return 32'(total_free);
            3:       return 32'(reject_cnt);
            4:       return 32'(underflow_err);
            5:       return 32'(peak_occ);
            6:       return 32'(seg);
            7:       return 32'(digit_sel);
            8:       return 32'(zone_full);
            9:       return 32'(zone_free);
            10:      return 32'(zone_free2);
            default: return 32'(e.idx);
        endcase
    endfunction

    // Monitor: drains every queued expectation on a requested sample edge.
    always @(negedge clk) begin : monitor
        expT         e;
        logic [31:0] act;
        if (sampleReq) begin
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = getActual(e);
                testCount++;
                if (act !== e.exp) begin
                    failCount++;
                    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int sel, input int idx, input logic [31:0] exp);
        expT e;
        e.name = name;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic flush();
        sampleReq = 1'b1;
        tick(1);
        sampleReq = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N_ZONES-1:0] inLvl, input logic [N_ZONES-1:0] outLvl,
                                 input int cycles);
        car_in  = inLvl;
        car_out = outLvl;
        tick(cycles);
    endtask

    task automatic pulseIn(input int z, input int count);
        repeat (count) begin
            applyStimulus(N_ZONES'(1 << z), '0, 1);
            applyStimulus('0, '0, 1);
        end
        tick(2);
    endtask

    task automatic pulseOut(input int z, input int count);
        repeat (count) begin
            applyStimulus('0, N_ZONES'(1 << z), 1);
            applyStimulus('0, '0, 1);
        end
        tick(2);
    endtask

    task automatic cfgWrite(input int z, input int cap);
        cfg_we   = 1'b1;
        cfg_zone = 3'(z);
        cfg_cap  = CW'(cap);
        tick(1);
        cfg_we   = 1'b0;
    endtask

    // Waits for the start of a fresh slot for digit v, then one cycle for seg.
    task automatic waitDigit(input logic v, input string name);
        int n = 0;
        while (digit_sel == v && n < 50) begin
            tick(1);
            n++;
        end
        while (digit_sel != v && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput(name, 11, (n >= 50) ? 1 : 0, 32'd0);
        tick(1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        tick(2);
        checkOutput("reset_zone_free", 9, 0, 32'h0);
        checkOutput("reset_zone_full", 8, 0, 32'hF);
        checkOutput("reset_total_free", 2, 0, 32'd0);
        checkOutput("reset_seg", 6, 0, 32'h7E);
        checkOutput("reset_digit_sel", 7, 0, 32'd0);
        checkOutput("reset_reject", 3, 0, 32'd0);
        checkOutput("reset_underflow", 4, 0, 32'd0);
        checkOutput("reset_peak", 5, 0, 32'd0);
        flush();
        testCount++;
        if (total_free !== TW'(0)) begin
            failCount++;
            $display("[TB] FAIL direct_reset_total: got %0d, expected 0", total_free);
        end
        testCount++;
        if (seg !== 7'b1111110) begin
            failCount++;
            $display("[TB] FAIL direct_reset_seg: got 0x%0h, expected 0x7e", seg);
        end
        testCount++;
        if (digit_sel !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL direct_reset_digit_sel: got %0b, expected 0", digit_sel);
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(1);

        // Zone 0 fills and rejects the fourth car
        cfgWrite(0, 3);
        pulseIn(0, 2);
        checkOutput("z0_free_after2", 0, 0, 32'd1);
        checkOutput("z0_full_after2", 1, 0, 32'd0);
        checkOutput("total_after2", 2, 0, 32'd1);
        flush();
        pulseIn(0, 2);
        checkOutput("z0_free_full", 0, 0, 32'd0);
        checkOutput("z0_full_set", 1, 0, 32'd1);
        checkOutput("reject_one", 3, 0, 32'd1);
        checkOutput("total_z0_full", 2, 0, 32'd0);
        flush();

        // Held sensor gives one event; disabled events are dropped
        cfgWrite(1, 5);
        applyStimulus(4'b0010, '0, 10);
        applyStimulus('0, '0, 3);
        checkOutput("z1_held_free", 0, 1, 32'd4);
        checkOutput("z1_held_full", 1, 1, 32'd0);
        checkOutput("total_z1", 2, 0, 32'd4);
        flush();
        enable = 1'b0;
        pulseIn(1, 1);
        checkOutput("z1_disabled_free", 0, 1, 32'd4);
        flush();
        applyStimulus(4'b0010, '0, 3);
        enable = 1'b1;
        applyStimulus(4'b0010, '0, 3);
        applyStimulus('0, '0, 3);
        checkOutput("z1_enable_while_high", 0, 1, 32'd4);
        flush();

        // Swap, underflow and sticky error
        cfgWrite(2, 4);
        pulseIn(2, 2);
        checkOutput("z2_two_in", 0, 2, 32'd2);
        flush();
        applyStimulus(4'b0100, 4'b0100, 1);
        applyStimulus('0, '0, 3);
        checkOutput("z2_swap_free", 0, 2, 32'd2);
        checkOutput("z2_swap_no_err", 4, 0, 32'd0);
        checkOutput("z2_swap_no_reject", 3, 0, 32'd1);
        flush();
        pulseOut(2, 2);
        checkOutput("z2_empty_free", 0, 2, 32'd4);
        checkOutput("z2_empty_no_err", 4, 0, 32'd0);
        flush();
        pulseOut(2, 1);
        checkOutput("z2_underflow_free", 0, 2, 32'd4);
        checkOutput("z2_underflow_set", 4, 0, 32'd1);
        flush();
        pulseIn(2, 1);
        checkOutput("z2_refill_free", 0, 2, 32'd3);
        checkOutput("underflow_sticky", 4, 0, 32'd1);
        checkOutput("total_z2", 2, 0, 32'd7);
        flush();

        // Capacity clamp and out-of-range zone
        cfgWrite(3, 8);
        pulseIn(3, 6);
        checkOutput("z3_six_in", 0, 3, 32'd2);
        checkOutput("total_z3", 2, 0, 32'd9);
        flush();
        cfgWrite(3, 4);
        checkOutput("z3_clamp_free", 0, 3, 32'd0);
        checkOutput("z3_clamp_full", 1, 3, 32'd1);
        flush();
        cfgWrite(3, 15);
        tick(2);
        checkOutput("z3_cap15_free", 0, 3, 32'd11);
        checkOutput("z3_cap15_full", 1, 3, 32'd0);
        checkOutput("total_18", 2, 0, 32'd18);
        flush();
        cfgWrite(5, 9);
        tick(2);
        checkOutput("bad_zone_total", 2, 0, 32'd18);
        checkOutput("bad_zone_free_vec", 9, 0, 32'hB340);
        flush();
        waitDigit(1'b0, "wait_tens_18");
        checkOutput("seg_tens_18", 6, 0, 32'h30);
        flush();
        waitDigit(1'b1, "wait_ones_18");
        checkOutput("seg_ones_18", 6, 0, 32'h7F);
        flush();

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        checkOutput("async_zone_free", 9, 0, 32'h0);
        checkOutput("async_zone_full", 8, 0, 32'hF);
        checkOutput("async_total", 2, 0, 32'd0);
        checkOutput("async_reject", 3, 0, 32'd0);
        checkOutput("async_underflow", 4, 0, 32'd0);
        checkOutput("async_seg", 6, 0, 32'h7E);
        checkOutput("async_digit_sel", 7, 0, 32'd0);
        flush();
        reset_n = 1'b1;
        tick(1);

        // Saturation on the small instance, then full lot display
        cfgWrite(0, 14);
        tick(1);
        checkOutput("sat_cap_small", 10, 0, 32'd10);
        checkOutput("cap14_big", 0, 0, 32'd14);
        flush();
        for (int z = 0; z < N_ZONES; z++) cfgWrite(z, 15);
        tick(3);
        checkOutput("total_60", 2, 0, 32'd60);
        checkOutput("none_full", 8, 0, 32'h0);
        flush();
        testCount++;
        if (total_free !== TW'(60)) begin
            failCount++;
            $display("[TB] FAIL direct_total_60: got %0d, expected 60", total_free);
        end
        testCount++;
        if (zone_full !== '0) begin
            failCount++;
            $display("[TB] FAIL direct_none_full: got 0x%0h, expected 0x0", zone_full);
        end
        waitDigit(1'b0, "wait_tens_60");
        checkOutput("seg_tens_60", 6, 0, 32'h5F);
        flush();
        waitDigit(1'b1, "wait_ones_60");
        checkOutput("seg_ones_60", 6, 0, 32'h7E);
        flush();

        pulseIn(0, 7);
        tick(2);
        checkOutput("total_53", 2, 0, 32'd53);
`ifdef PEAK_HOLD_EN
        checkOutput("peak_7", 5, 0, 32'd7);
`else
        checkOutput("peak_tied_0", 5, 0, 32'd0);
`endif
        flush();
        waitDigit(1'b0, "wait_tens_53");
        checkOutput("seg_tens_53", 6, 0, 32'h5B);
        flush();
        waitDigit(1'b1, "wait_ones_53");
        checkOutput("seg_ones_53", 6, 0, 32'h79);
        flush();
        cfgWrite(1, 15);
        checkOutput("peak_cleared", 5, 0, 32'd0);
        flush();
        tick(1);
`ifdef PEAK_HOLD_EN
        checkOutput("peak_retracks", 5, 0, 32'd7);
`else
        checkOutput("peak_still_0", 5, 0, 32'd0);
`endif
        flush();

        tick(2);
        testCount++;
        if (total_free !== TW'(53)) begin
            failCount++;
            $display("[TB] FAIL direct_total_53: got %0d, expected 53", total_free);
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
